// File: rtl/apb_master_bridge.sv
// APB master bridge: valid/ready command in, APB SETUP/ACCESS transfer out, one-cycle response pulse.
// Define APB_TIMEOUT_EN to add the TIMEOUT_CYC parameter and force an error after a stalled ACCESS.
module apb_master_bridge #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
`ifdef APB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 16
`endif
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [DATA_W-1:0] CMD_WDATA,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              RSP_ERR,
    output logic              PSEL,
    output logic              PEN,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    input  logic [DATA_W-1:0] PRDATA
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t            state;
    state_t            state_d;
    logic              psel_d;
    logic              pen_d;
    logic              pwrite_d;
    logic [ADDR_W-1:0] paddr_d;
    logic [DATA_W-1:0] pwdata_d;
    logic              rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic              rsp_err_d;
    logic              ready_d;
    logic              done;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;

    // The cycle that would be the TIMEOUT_CYC-th stalled ACCESS cycle completes the transfer instead.
    assign tmo_hit = (state == S_ACCESS) && !PREADY && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tmo_cnt <= '0;
        end else if (state_d == S_SETUP) begin
            tmo_cnt <= '0;
        end else if ((state == S_ACCESS) && !PREADY && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d     = state;
        psel_d      = PSEL;
        pen_d       = PEN;
        pwrite_d    = PWRITE;
        paddr_d     = PADDR;
        pwdata_d    = PWDATA;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = RSP_RDATA;
        rsp_err_d   = RSP_ERR;
        done        = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (CMD_VALID && CMD_READY) begin
                    pwrite_d = CMD_WRITE;
                    paddr_d  = CMD_ADDR;
                    pwdata_d = CMD_WDATA;
                    psel_d   = 1'b1;
                    pen_d    = 1'b0;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                pen_d   = 1'b1;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (PREADY) begin
                    done        = 1'b1;
                    rsp_rdata_d = PWRITE ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                end
`ifdef APB_TIMEOUT_EN
                else if (tmo_hit) begin
                    done        = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end
`endif
                if (done) begin
                    rsp_valid_d = 1'b1;
                    psel_d      = 1'b0;
                    pen_d       = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Ready stays low in the response cycle, forcing one idle cycle between transfers.
        ready_d = (state == S_IDLE) && (state_d == S_IDLE);
    end

    // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            CMD_READY <= 1'b0;
            PSEL      <= 1'b0;
            PEN       <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
            RSP_ERR   <= 1'b0;
        end else begin
            state     <= state_d;
            CMD_READY <= ready_d;
            PSEL      <= psel_d;
            PEN       <= pen_d;
            PWRITE    <= pwrite_d;
            PADDR     <= paddr_d;
            PWDATA    <= pwdata_d;
            RSP_VALID <= rsp_valid_d;
            RSP_RDATA <= rsp_rdata_d;
            RSP_ERR   <= rsp_err_d;
        end
    end

endmodule
